// File: rtl/multi_prior_scanner.sv
// multi_prior_scanner: captures a request vector through a valid/ready
// handshake and emits the indices of its set bits one beat at a time, in a
// fixed scan direction, up to MAX_OUT beats, with popcount and shortfall flags.
module multi_prior_scanner #(
    parameter int WIDTH     = 16,
    parameter int IDXW      = 4,
    parameter int MAX_OUT   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic [IDXW-1:0]   out_rank,
    output logic              out_last,
    output logic              out_none,
    output logic              out_short,
    output logic [IDXW:0]     out_cnt
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  work;
    logic [WIDTH-1:0]  work_rest;
    logic [IDXW-1:0]   rank;
    logic [IDXW:0]     cnt;
    logic [IDXW:0]     pop;
    logic [IDXW-1:0]   pos;
    logic [IDXW-1:0]   hit_idx;
    logic              hit_found;

    // Popcount of the incoming vector; at most WIDTH, which always fits IDXW+1 bits.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + (IDXW+1)'(in_vec[i]);
        end
    end

    // Find-first set bit of the working register in scan direction, and the
    // register contents once that bit is retired.
    always_comb begin
        pos       = '0;
        hit_idx   = '1;
        hit_found = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            pos = (MSB_FIRST != 0) ? IDXW'(WIDTH - 1 - k) : IDXW'(k);
            if (!hit_found && work[pos]) begin
                hit_found = 1'b1;
                hit_idx   = pos;
            end
        end
        work_rest = work;
        if (hit_found) begin
            work_rest[hit_idx] = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; outputs depend only on registered state,
    // so they hold steady while the consumer stalls.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '1;
        out_rank  = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        out_short = 1'b0;
        out_cnt   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_idx   = hit_idx;
                out_rank  = rank;
                out_last  = (work_rest == '0) || (rank == IDXW'(MAX_OUT - 1));
                out_none  = (cnt == '0);
                out_short = out_last && (cnt < (IDXW+1)'(MAX_OUT));
                out_cnt   = cnt;
                if (out_ready && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working register, beat counter and captured popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            rank <= '0;
            cnt  <= '0;
        end else if (state == IDLE && in_valid) begin
            work <= in_vec;
            rank <= '0;
            cnt  <= pop;
        end else if (state == EMIT && out_ready) begin
            work <= work_rest;
            rank <= rank + 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_prior_scanner.sv
// Self-checking bench for multi_prior_scanner: default instance plus an
// 8-bit LSB-first instance, hand-written vector table, corner sequences and
// randomized vectors checked against a scan-order reference model.
module tb_multi_prior_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_vec;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last, a_out_none, a_out_short;
    logic [3:0]  a_out_idx, a_out_rank;
    logic [4:0]  a_out_cnt;
    logic        b_in_ready, b_out_valid, b_out_last, b_out_none, b_out_short;
    logic [2:0]  b_out_idx, b_out_rank;
    logic [3:0]  b_out_cnt;

    always #5 clk = ~clk;

    multi_prior_scanner dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_vec(in_vec), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_idx(a_out_idx), .out_rank(a_out_rank), .out_last(a_out_last),
        .out_none(a_out_none), .out_short(a_out_short), .out_cnt(a_out_cnt)
    );

    multi_prior_scanner #(.WIDTH(8), .IDXW(3), .MAX_OUT(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_vec(in_vec[7:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_idx(b_out_idx), .out_rank(b_out_rank), .out_last(b_out_last),
        .out_none(b_out_none), .out_short(b_out_short), .out_cnt(b_out_cnt)
    );

    bit sel = 1'b0;
    int o_valid, o_in_ready, o_idx, o_rank, o_last, o_none, o_short, o_cnt;

    always_comb begin
        if (sel) begin
            o_valid = int'(b_out_valid); o_in_ready = int'(b_in_ready);
            o_idx = int'(b_out_idx); o_rank = int'(b_out_rank); o_last = int'(b_out_last);
            o_none = int'(b_out_none); o_short = int'(b_out_short); o_cnt = int'(b_out_cnt);
        end else begin
            o_valid = int'(a_out_valid); o_in_ready = int'(a_in_ready);
            o_idx = int'(a_out_idx); o_rank = int'(a_out_rank); o_last = int'(a_out_last);
            o_none = int'(a_out_none); o_short = int'(a_out_short); o_cnt = int'(a_out_cnt);
        end
    end

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int idx; int rank; int last; int none; int shrt; int cnt;
    } beat_t;

    beat_t exp_q[$];

    function automatic longint pack(input int idx, input int rank, input int last,
                                    input int none, input int shrt, input int cnt);
        return (longint'(idx) << 40) | (longint'(rank) << 32) | (longint'(last) << 24) |
               (longint'(none) << 16) | (longint'(shrt) << 8) | longint'(cnt);
    endfunction

    // Reference: list set bits in scan order, emit min(popcount, max_out) of
    // them (or one "none" beat for an empty vector).
    task automatic build_model(input logic [15:0] v, input int w, input int mo,
                               input bit msbf, input int iw);
        int    order[$];
        beat_t b;
        int    nb;
        exp_q.delete();
        for (int k = 0; k < w; k++) begin
            int p;
            p = msbf ? (w - 1 - k) : k;
            if (((v >> p) & 16'h1) != 16'h0) order.push_back(p);
        end
        if (order.size() == 0) begin
            b = '{(1 << iw) - 1, 0, 1, 1, 1, 0};
            exp_q.push_back(b);
        end else begin
            nb = (order.size() < mo) ? order.size() : mo;
            for (int r = 0; r < nb; r++) begin
                b.idx  = order[r];
                b.rank = r;
                b.last = (r == nb - 1) ? 1 : 0;
                b.none = 0;
                b.shrt = ((r == nb - 1) && (order.size() < mo)) ? 1 : 0;
                b.cnt  = order.size();
                exp_q.push_back(b);
            end
        end
    endtask

    int got_n, got_first, got_lastidx, got_cnt, got_short, got_cycles;

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called at posedge+1 with the selected DUT idle: send one vector, then
    // consume its beats, checking every cycle against the model.
    task automatic run_vec(input logic [15:0] v, input int stall, input bit rnd_ready);
        int  n;
        int  k;
        int  cyc;
        bit  done;
        bit  rdy;
        if (sel) build_model(v, 8, 8, 1'b0, 3);
        else     build_model(v, 16, 2, 1'b1, 4);
        in_valid = 1'b1;
        in_vec   = v;
        n = 0;
        while (o_in_ready == 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("send_in_ready", o_in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
        k = 0; cyc = 0; done = 1'b0;
        got_n = 0; got_first = -1; got_lastidx = -1; got_cnt = -1; got_short = -1;
        while (!done && cyc < 100) begin
            if (cyc < stall)     rdy = 1'b0;
            else if (rnd_ready)  rdy = ($urandom_range(0, 3) != 0);
            else                 rdy = 1'b1;
            out_ready = rdy;
            chk("busy_out_valid", o_valid, 1);
            chk("busy_in_ready", o_in_ready, 0);
            if (k < exp_q.size()) begin
                chk("beat_fields",
                    pack(o_idx, o_rank, o_last, o_none, o_short, o_cnt),
                    pack(exp_q[k].idx, exp_q[k].rank, exp_q[k].last,
                         exp_q[k].none, exp_q[k].shrt, exp_q[k].cnt));
            end
            if (o_valid != 0 && rdy) begin
                if (k == 0) got_first = o_idx;
                got_lastidx = o_idx;
                got_cnt = o_cnt;
                got_short = o_short;
                k++;
                if (o_last != 0 || k > 16) done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        got_n = k;
        got_cycles = cyc;
        chk("vector_completed", done, 1);
        chk("beat_count_model", k, exp_q.size());
        chk("post_out_valid", o_valid, 0);
        chk("post_in_ready", o_in_ready, 1);
    endtask

    typedef struct {
        bit          dsel;
        logic [15:0] vec;
        int          stall;
        int          nb;
        int          idx0;
        int          idxl;
        int          cnt;
        int          shrt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 16'h8421, 0, 2, 15, 10, 4, 0};
        tbl[1] = '{1'b0, 16'h0001, 0, 1, 0, 0, 1, 1};
        tbl[2] = '{1'b0, 16'h0000, 0, 1, 15, 15, 0, 1};
        tbl[3] = '{1'b0, 16'hC000, 3, 2, 15, 14, 2, 0};
        tbl[4] = '{1'b0, 16'hFFFF, 0, 2, 15, 14, 16, 0};
        tbl[5] = '{1'b0, 16'h8000, 0, 1, 15, 15, 1, 1};
        tbl[6] = '{1'b0, 16'h0003, 0, 2, 1, 0, 2, 0};
        tbl[7] = '{1'b1, 16'h00FF, 0, 8, 0, 7, 8, 0};
        tbl[8] = '{1'b1, 16'h0000, 0, 1, 7, 7, 0, 1};
        tbl[9] = '{1'b1, 16'h0080, 0, 1, 7, 7, 1, 1};

        in_vec = '0;
        do_reset();
        chk("reset_in_ready", o_in_ready, 1);
        chk("reset_out_valid", o_valid, 0);
        chk("reset_out_idx", o_idx, 15);
        chk("reset_out_rank", o_rank, 0);
        chk("reset_out_cnt", o_cnt, 0);
        chk("reset_flags", pack(0, 0, o_last, o_none, o_short, 0), 0);

        // Hand-computed vector table.
        for (int t = 0; t < 10; t++) begin
            if (tbl[t].dsel != sel) begin
                do_reset();
                sel = tbl[t].dsel;
            end
            run_vec(tbl[t].vec, tbl[t].stall, 1'b0);
            chk("tbl_beats", got_n, tbl[t].nb);
            chk("tbl_first_idx", got_first, tbl[t].idx0);
            chk("tbl_last_idx", got_lastidx, tbl[t].idxl);
            chk("tbl_cnt", got_cnt, tbl[t].cnt);
            chk("tbl_short", got_short, tbl[t].shrt);
            chk("tbl_cycles", got_cycles, tbl[t].nb + tbl[t].stall);
        end

        // Randomized vectors on the 8-bit LSB-first instance.
        for (int i = 0; i < 12; i++) begin
            logic [15:0] v;
            v = {8'h00, 8'($urandom)};
            if (i % 3 == 0) v = v & {8'h00, 8'($urandom)};
            run_vec(v, int'($urandom_range(0, 2)), 1'b1);
        end

        do_reset();
        sel = 1'b0;

        // Reset while a vector is mid-scan and stalled.
        in_valid  = 1'b1;
        in_vec    = 16'hFFFF;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midrst_valid_before", o_valid, 1);
        @(posedge clk); #1;
        chk("midrst_idx_held", o_idx, 15);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", o_valid, 0);
        chk("midrst_in_ready", o_in_ready, 1);
        chk("midrst_out_idx", o_idx, 15);
        run_vec(16'h0100, 0, 1'b0);
        chk("midrst_next_idx", got_first, 8);
        chk("midrst_next_beats", got_n, 1);

        // Randomized vectors on the default instance, with random back-pressure.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (i % 3 == 0) v = v & 16'($urandom);
            if (i % 5 == 0) v = v & 16'($urandom) & 16'($urandom);
            if (i % 11 == 0) v = 16'h0000;
            run_vec(v, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_prior_scanner.md
Name: multi_prior_scanner

Overview:
- Parametrised, sequential successor to the combinational dual priority encoder.
- Captures a WIDTH-bit request vector through a valid/ready handshake.
- Emits the indices of its set bits one beat at a time, up to MAX_OUT beats, in a programmable scan direction, with popcount and shortfall flags.
- Sits between request-collection logic and a downstream arbiter or grant sequencer that consumes one index per cycle.

Parameters:
- WIDTH, 16, request vector width; must be ≥2.
- IDXW, 4, index width; must equal ceil(log2(WIDTH)).
- MAX_OUT, 2, maximum indices emitted per captured vector; must be 1..WIDTH.
- MSB_FIRST, 1, 1 = scan from bit WIDTH-1 downward, 0 = scan from bit 0 upward.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_vec is valid.
- in_ready, output, 1, block can accept a vector.
- in_vec, input, WIDTH, request vector.
- out_valid, output, 1, out_* fields are valid.
- out_ready, input, 1, downstream accepts the current beat.
- out_idx, output, IDXW, index of the set bit found; all-ones when out_none=1.
- out_rank, output, IDXW, 0-based ordinal of this beat within the current vector.
- out_last, output, 1, final beat for this vector.
- out_none, output, 1, captured vector was all zeros.
- out_short, output, 1, on the final beat only: popcount < MAX_OUT.
- out_cnt, output, IDXW+1, popcount of the captured vector; valid whenever out_valid=1.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE.
  - in_ready=1, out_valid=0.
  - out_idx=all-ones; out_rank, out_last, out_none, out_short, out_cnt = 0.
  - Working register and beat counter cleared.
  - Reset has priority over every other event, including mid-scan; any in-flight vector is discarded with no further beats.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: capture in_vec into the working register and compute out_cnt.
  - Set rank=0 and go to EMIT.
  - Latency: first beat has out_valid=1 in the cycle after capture.
- EMIT:
  - in_ready=0.
  - out_idx = first set bit of the working register in scan direction, from a combinational find-first over the WIDTH bits.
  - out_rank = beat counter.
- Output holding: out_valid and all out_* fields stay stable while out_valid & !out_ready. No field changes during back-pressure.
- On out_valid & out_ready:
  - Clear the emitted bit in the working register and increment rank.
  - If out_last: go to IDLE. in_ready=1 in the following cycle; no same-cycle re-accept.
- out_last is asserted when either:
  - no set bits remain after clearing the current bit, or
  - rank == MAX_OUT-1.
- Empty vector (in_vec = 0): exactly one beat with out_none=1, out_idx=all-ones, out_last=1, out_short=1, out_cnt=0, out_rank=0.
- out_short: asserted only on the final beat, and only when out_cnt < MAX_OUT. Held 0 on all other beats.
- out_cnt: saturates at WIDTH, which fits in IDXW+1 bits. Value is held for the whole vector.
- Beats per vector: min(popcount, MAX_OUT), or 1 if popcount = 0.
- Index boundaries: bit 0 and bit WIDTH-1 must both be reachable. Emitted indices are never duplicated within a vector.
- in_vec changing while in EMIT has no effect.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst=1 for 2 cycles, then release.
  - Required: in_ready=1, out_valid=0, out_idx=4'hF.
- Basic scan, defaults (MSB_FIRST=1, MAX_OUT=2):
  - Stimulus: in_vec=16'h8421, out_ready=1.
  - Required: beat0 idx=15 rank=0 last=0; beat1 idx=10 rank=1 last=1 short=0; out_cnt=4; in_ready=1 one cycle after beat1.
- Single bit and empty:
  - Stimulus: in_vec=16'h0001.
  - Required: one beat, idx=0, last=1, short=1, cnt=1.
  - Stimulus: in_vec=16'h0000.
  - Required: one beat, idx=4'hF, none=1, last=1, short=1, cnt=0.
- Back-pressure:
  - Stimulus: in_vec=16'hC000, out_ready=0 for 3 cycles, then 1.
  - Required: idx=15 held stable for all 4 cycles; next beat idx=14 last=1.
- Parameter sweep (WIDTH=8, IDXW=3, MAX_OUT=8, MSB_FIRST=0):
  - Stimulus: in_vec=8'hFF.
  - Required: idx 0..7 on consecutive cycles, last only on idx=7, cnt=8, short=0.
- Reset mid-operation:
  - Stimulus: in_vec=16'hFFFF with out_ready=0; assert rst during EMIT.
  - Required: out_valid=0 the next cycle, in_ready=1; next vector 16'h0100 yields idx=8, rank=0.
